// File: rtl/we_event_monitor_if.sv
// Bus bundle for we_event_monitor: event inputs, host snapshot handshake and readout.
// master = host/status side driving requests, slave = the monitor itself.
interface we_event_monitor_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
);
    logic [N_CH-1:0]  evt_in;
    logic [N_CH-1:0]  ch_mask;
    logic             clr_req;
    logic             snap_req;
    logic             snap_ack;
    logic [SEL_W-1:0] rd_sel;
    logic [N_CH-1:0]  evt_pulse;
    logic [N_CH-1:0]  evt_sticky;
    logic [N_CH-1:0]  ovf;
    logic             snap_valid;
    logic             snap_overrun;
    logic [CNT_W-1:0] rd_cnt;

    modport master (
        output evt_in, ch_mask, clr_req, snap_req, snap_ack, rd_sel,
        input  evt_pulse, evt_sticky, ovf, snap_valid, snap_overrun, rd_cnt
    );

    modport slave (
        input  evt_in, ch_mask, clr_req, snap_req, snap_ack, rd_sel,
        output evt_pulse, evt_sticky, ovf, snap_valid, snap_overrun, rd_cnt
    );
endinterface

// File: rtl/we_event_monitor.sv
// N-channel event monitor: edge pulses, sticky flags, counters and a host snapshot bank.
// Define WE_EVT_SATURATE_EN to make counters saturate instead of wrapping on overflow.
module we_event_monitor #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
) (
    input logic               weClk,
    input logic               rst_we,
    we_event_monitor_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [N_CH-1:0]  evt_q;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  evt_pulse;
    logic [N_CH-1:0]  evt_sticky;
    logic [N_CH-1:0]  ovf;
    logic             snap_valid;
    logic             snap_overrun;
    logic [CNT_W-1:0] cnt    [N_CH];
    logic [CNT_W-1:0] shadow [N_CH];
    logic [CNT_W-1:0] rd_cnt;

    // evt_q tracks the raw input even on masked channels, so unmasking a high input gives no edge.
    assign rise = bus.evt_in & ~evt_q & bus.ch_mask;

    always_ff @(posedge weClk or posedge rst_we) begin
        if (rst_we) begin
            evt_q      <= '0;
            evt_pulse  <= '0;
            evt_sticky <= '0;
            ovf        <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            evt_q     <= bus.evt_in;
            evt_pulse <= rise;
            if (bus.clr_req) begin
                evt_sticky <= '0;
                ovf        <= '0;
                for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    if (rise[i]) begin
                        evt_sticky[i] <= 1'b1;
                        if (cnt[i] == CNT_MAX) begin
                            ovf[i] <= 1'b1;
`ifdef WE_EVT_SATURATE_EN
                            cnt[i] <= CNT_MAX;
`else
                            cnt[i] <= '0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Ack and req together in HOLD hands the host a fresh capture without dropping snap_valid.
    always_ff @(posedge weClk or posedge rst_we) begin
        if (rst_we) begin
            state        <= IDLE;
            snap_valid   <= 1'b0;
            snap_overrun <= 1'b0;
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
        end else if (bus.clr_req) begin
            state        <= IDLE;
            snap_valid   <= 1'b0;
            snap_overrun <= 1'b0;
            for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.snap_req) begin
                        for (int i = 0; i < N_CH; i++) shadow[i] <= cnt[i];
                        state      <= HOLD;
                        snap_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.snap_ack && bus.snap_req) begin
                        for (int i = 0; i < N_CH; i++) shadow[i] <= cnt[i];
                    end else if (bus.snap_ack) begin
                        state      <= IDLE;
                        snap_valid <= 1'b0;
                    end else if (bus.snap_req) begin
                        snap_overrun <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_sel == SEL_W'(i)) rd_cnt = shadow[i];
        end
    end

    assign bus.evt_pulse    = evt_pulse;
    assign bus.evt_sticky   = evt_sticky;
    assign bus.ovf          = ovf;
    assign bus.snap_valid   = snap_valid;
    assign bus.snap_overrun = snap_overrun;
    assign bus.rd_cnt       = rd_cnt;
endmodule

// File: tb/tb_we_event_monitor.sv
// Directed bench for we_event_monitor: a 32-bit instance plus an 8-bit instance for overflow.
// Both instances share the same stimulus.
module tb_we_event_monitor;
    logic       weClk    = 1'b0;
    logic       rst_we   = 1'b1;
    logic [3:0] evt_in   = '0;
    logic [3:0] ch_mask  = '0;
    logic       clr_req  = 1'b0;
    logic       snap_req = 1'b0;
    logic       snap_ack = 1'b0;
    logic [3:0] rd_sel   = '0;
    int         checks   = 0;
    int         errors   = 0;

`ifdef WE_EVT_SATURATE_EN
    localparam logic [31:0] EXP_CNT8_CH1 = 32'd255;
`else
    localparam logic [31:0] EXP_CNT8_CH1 = 32'd1;
`endif

    we_event_monitor_if #(.N_CH(4), .CNT_W(32), .SEL_W(4)) bus ();
    we_event_monitor_if #(.N_CH(4), .CNT_W(8), .SEL_W(4)) bus8 ();

    assign bus.evt_in    = evt_in;
    assign bus.ch_mask   = ch_mask;
    assign bus.clr_req   = clr_req;
    assign bus.snap_req  = snap_req;
    assign bus.snap_ack  = snap_ack;
    assign bus.rd_sel    = rd_sel;
    assign bus8.evt_in   = evt_in;
    assign bus8.ch_mask  = ch_mask;
    assign bus8.clr_req  = clr_req;
    assign bus8.snap_req = snap_req;
    assign bus8.snap_ack = snap_ack;
    assign bus8.rd_sel   = rd_sel;

    we_event_monitor #(.N_CH(4), .CNT_W(32), .SEL_W(4)) dut (
        .weClk (weClk),
        .rst_we(rst_we),
        .bus   (bus)
    );

    we_event_monitor #(.N_CH(4), .CNT_W(8), .SEL_W(4)) dut8 (
        .weClk (weClk),
        .rst_we(rst_we),
        .bus   (bus8)
    );

    always #5 weClk = ~weClk;

    task automatic tick();
        @(posedge weClk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic rise_evt(input int ch);
        evt_in[ch] = 1'b1;
        tick();
        check_output("pulse_high", 32'(bus.evt_pulse), 32'(4'b0001 << ch));
        evt_in[ch] = 1'b0;
        tick();
        check_output("pulse_low", 32'(bus.evt_pulse), 32'd0);
    endtask

    task automatic apply_stimulus(input logic req, input logic ack, input logic clr);
        snap_req = req;
        snap_ack = ack;
        clr_req  = clr;
        tick();
        snap_req = 1'b0;
        snap_ack = 1'b0;
        clr_req  = 1'b0;
    endtask

    initial begin
        #100us;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tick();
        tick();
        check_output("rst_pulse", 32'(bus.evt_pulse), 32'd0);
        check_output("rst_sticky", 32'(bus.evt_sticky), 32'd0);
        check_output("rst_ovf", 32'(bus.ovf), 32'd0);
        check_output("rst_valid", 32'(bus.snap_valid), 32'd0);
        check_output("rst_overrun", 32'(bus.snap_overrun), 32'd0);
        check_output("rst_rdcnt", bus.rd_cnt, 32'd0);
        rst_we = 1'b0;

        // Reset mid-count clears asynchronously; no pulse after release without a new edge.
        ch_mask = 4'hF;
        evt_in  = 4'b0001;
        tick();
        check_output("pre_rst_pulse", 32'(bus.evt_pulse), 32'd1);
        check_output("pre_rst_sticky", 32'(bus.evt_sticky), 32'd1);
        #2 rst_we = 1'b1;
        #1;
        check_output("async_rst_pulse", 32'(bus.evt_pulse), 32'd0);
        check_output("async_rst_sticky", 32'(bus.evt_sticky), 32'd0);
        evt_in = 4'b0000;
        tick();
        rst_we = 1'b0;
        tick();
        check_output("post_rst_pulse", 32'(bus.evt_pulse), 32'd0);

        // Five edges on ch0 then a snapshot.
        for (int k = 0; k < 5; k++) rise_evt(0);
        check_output("sticky_ch0", 32'(bus.evt_sticky), 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("snap_valid_set", 32'(bus.snap_valid), 32'd1);
        rd_sel = 4'd0; #1;
        check_output("rd_ch0", bus.rd_cnt, 32'd5);
        rd_sel = 4'd1; #1;
        check_output("rd_ch1", bus.rd_cnt, 32'd0);
        rd_sel = 4'd9; #1;
        check_output("rd_sel_oob", bus.rd_cnt, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("snap_valid_clr", 32'(bus.snap_valid), 32'd0);

        // 257 edges on ch1: wraps (or saturates) the 8-bit counter.
        for (int k = 0; k < 257; k++) begin
            evt_in[1] = 1'b1;
            tick();
            evt_in[1] = 1'b0;
            tick();
        end
        check_output("ovf8", 32'(bus8.ovf), 32'b0010);
        check_output("ovf32", 32'(bus.ovf), 32'd0);
        check_output("sticky_ch01", 32'(bus.evt_sticky), 32'b0011);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        rd_sel = 4'd1; #1;
        check_output("rd8_ch1", 32'(bus8.rd_cnt), EXP_CNT8_CH1);
        check_output("rd32_ch1", bus.rd_cnt, 32'd257);
        apply_stimulus(1'b0, 1'b1, 1'b0);

        // Masked high input, then unmask: no pulse; a fresh edge counts once.
        ch_mask   = 4'b1011;
        evt_in[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_output("masked_pulse", 32'(bus.evt_pulse), 32'd0);
        end
        ch_mask = 4'hF;
        tick();
        check_output("unmask_pulse", 32'(bus.evt_pulse), 32'd0);
        tick();
        check_output("unmask_pulse2", 32'(bus.evt_pulse), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        rd_sel = 4'd2; #1;
        check_output("rd_ch2_zero", bus.rd_cnt, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        evt_in[2] = 1'b0;
        tick();
        rise_evt(2);
        check_output("sticky_ch012", 32'(bus.evt_sticky), 32'b0111);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        #1;
        check_output("rd_ch2_one", bus.rd_cnt, 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);

        // Handshake: overrun in HOLD, then ack+req recapture, then ack alone.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("overrun_before", 32'(bus.snap_overrun), 32'd0);
        for (int k = 0; k < 3; k++) rise_evt(0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("overrun_set", 32'(bus.snap_overrun), 32'd1);
        check_output("hold_valid", 32'(bus.snap_valid), 32'd1);
        rd_sel = 4'd0; #1;
        check_output("hold_rd_ch0", bus.rd_cnt, 32'd5);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("recap_valid", 32'(bus.snap_valid), 32'd1);
        check_output("recap_rd_ch0", bus.rd_cnt, 32'd8);
        check_output("recap_overrun", 32'(bus.snap_overrun), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("ack_valid", 32'(bus.snap_valid), 32'd0);
        check_output("ack_shadow_kept", bus.rd_cnt, 32'd8);

        // Collision: clear, snapshot request and a ch3 edge on the same cycle.
        rise_evt(3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("pre_clr_valid", 32'(bus.snap_valid), 32'd1);
        evt_in[3] = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("clr_pulse", 32'(bus.evt_pulse), 32'b1000);
        check_output("clr_sticky", 32'(bus.evt_sticky), 32'd0);
        check_output("clr_ovf8", 32'(bus8.ovf), 32'd0);
        check_output("clr_valid", 32'(bus.snap_valid), 32'd0);
        check_output("clr_overrun", 32'(bus.snap_overrun), 32'd0);
        rd_sel = 4'd3; #1;
        check_output("clr_shadow", bus.rd_cnt, 32'd0);
        evt_in[3] = 1'b0;
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0);
        #1;
        check_output("clr_cnt_ch3", bus.rd_cnt, 32'd0);
        rd_sel = 4'd0; #1;
        check_output("clr_cnt_ch0", bus.rd_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
